mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative multiply/divide unit in the EX stage, beside alu, fed by the same A/B operands.
//  Executes MULT/MULTU/DIV/DIVU into architectural HI/LO registers and handles MTHI/MTLO.
//  Controller stalls the pipeline while busy=1; MFHI/MFLO read hi/lo through the EX result mux.
// PARAMETERS
//  W        32   operand width; only 32 supported (counter is 5 bits)
// PORTS
//  clk      in   1   clock; all state updates on posedge
//  rst      in   1   reset: asynchronous, active-high; clears all state
//  start    in   1   request; accepted only on a posedge where start=1 and busy=0
//  md_op    in   3   000 nop, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 nop
//  A        in   32  rs operand (multiplicand / dividend / MTHI-MTLO source)
//  B        in   32  rt operand (multiplier / divisor)
//  abort    in   1   flush from hazard/exception logic; cancels in-flight op
//  busy     out  1   1 while state != IDLE (combinational from state)
//  done     out  1   one-cycle pulse in the cycle after HI/LO are written by MULT*/DIV*
//  hi       out  32  HI register
//  lo       out  32  LO register
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal regs 0.
//  FSM: IDLE -> CALC -> FIX -> IDLE.
//   IDLE: on accepted start with md_op 001..100: latch |A|,|B| (two's-comp magnitude for signed ops;
//     raw for unsigned), latch result signs, latch original A, counter=0, go CALC.
//     md_op 101/110: write hi/lo=A at that edge, stay IDLE, no done, busy stays 0.
//     md_op 000/111: ignored.
//   CALC: exactly 32 cycles, one bit per cycle; counter 0..31; on counter==31 go FIX.
//     MUL: radix-2 shift-add on a 64-bit {acc,multiplier} register, 33-bit add to avoid carry loss.
//     DIV: restoring; 33-bit trial subtract of divisor from {rem,dividend} shifted left by 1.
//   FIX: apply sign. MULT: 64-bit product negated if signs of A and B differ.
//     DIV: quotient negated if signs differ; remainder takes sign of dividend.
//     Write {hi,lo} at this edge, assert done for the following cycle, go IDLE.
//  Latency: accept edge E0; hi/lo updated at E33; busy=1 from E0 through E33; done=1 for E33..E34.
//   Constant latency for all MULT*/DIV* operands, including divide-by-zero.
//  Widths: product is full 64 bits, hi=[63:32], lo=[31:0]. DIV: lo=quotient, hi=remainder.
//  Boundaries:
//   Divide by zero (B==0, DIV or DIVU): lo=32'hFFFF_FFFF, hi=original A; full 33 cycles.
//   DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0 (wraps; no trap, no flag).
//   |A|=2^31 for signed ops: magnitude held as unsigned 32-bit 32'h8000_0000 (correct).
//   start while busy: ignored entirely, including MTHI/MTLO; issuer must hold the stall.
//   abort with busy=1: state->IDLE at next edge, hi/lo unchanged, no done.
//   abort in FIX cycle: abort wins; hi/lo not written, no done.
//   abort with start in IDLE: abort wins; request dropped, incl. MTHI/MTLO.
//   Async rst mid-op: immediate IDLE; hi/lo=0; no done after release.
//   hi/lo hold value between ops; reads never stall when busy=0.
// TESTING
//  rst pulse mid-CALC -> busy,done,hi,lo all 0 immediately; next start behaves normally.
//  MULT A=32'hFFFF_FFFE(-2) B=3 -> after 33 cycles hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA, done 1 cycle.
//  MULTU A=B=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001.
//  DIV A=-7 B=2 -> lo=32'hFFFF_FFFD(-3), hi=32'hFFFF_FFFF(-1); DIVU A=7 B=0 -> lo=32'hFFFF_FFFF, hi=7.
//  DIV A=32'h8000_0000 B=32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0, no hang.
//  MTHI A=32'h1234_5678 in IDLE -> hi next cycle, busy never 1.
//  MTLO during busy -> lo unchanged.
//  abort at cycle 10 of DIVU -> hi/lo keep prior values, no done, busy=0 next cycle.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the EX-stage controller and the multiply/divide unit.
// The master drives the operation request; the slave returns status and the HI/LO registers.
interface mul_div_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, A, B, abort,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, md_op, A, B, abort,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Magnitudes are processed one bit per cycle for 32 cycles; signs are applied in a final FIX cycle.
module mul_div_unit #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [W-1:0]   acc_q, acc_d;       // product high half / partial remainder
    logic [W-1:0]   mq_q, mq_d;         // multiplier / dividend shifting into quotient
    logic [W-1:0]   opnd_q, opnd_d;     // |multiplicand| or |divisor|
    logic [W-1:0]   a_orig_q, a_orig_d;
    logic           is_div_q, is_div_d;
    logic           neg_res_q, neg_res_d;
    logic           neg_rem_q, neg_rem_d;
    logic           div0_q, div0_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           done_q, done_d;

    logic           op_signed;
    logic           op_div;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [W:0]     mul_sum;
    logic [W:0]     rem_shift;
    logic [W:0]     rem_diff;
    logic [2*W-1:0] prod_mag;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix;
    logic [W-1:0]   rem_fix;

    assign op_signed = (bus.md_op == OP_MULT) || (bus.md_op == OP_DIV);
    assign op_div    = (bus.md_op == OP_DIV)  || (bus.md_op == OP_DIVU);
    // 2^31 negates to itself and is then read as an unsigned magnitude
    assign a_mag     = (op_signed && bus.A[W-1]) ? (~bus.A + 1'b1) : bus.A;
    assign b_mag     = (op_signed && bus.B[W-1]) ? (~bus.B + 1'b1) : bus.B;

    assign mul_sum   = mq_q[0] ? ({1'b0, acc_q} + {1'b0, opnd_q}) : {1'b0, acc_q};
    assign rem_shift = {acc_q, mq_q[W-1]};
    assign rem_diff  = rem_shift - {1'b0, opnd_q};

    assign prod_mag  = {acc_q, mq_q};
    assign prod_fix  = neg_res_q ? (~prod_mag + 1'b1) : prod_mag;
    assign quot_fix  = neg_res_q ? (~mq_q + 1'b1) : mq_q;
    assign rem_fix   = neg_rem_q ? (~acc_q + 1'b1) : acc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opnd_d    = opnd_q;
        a_orig_d  = a_orig_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    case (bus.md_op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d   = CALC;
                            cnt_d     = '0;
                            acc_d     = '0;
                            mq_d      = op_div ? a_mag : b_mag;
                            opnd_d    = op_div ? b_mag : a_mag;
                            a_orig_d  = bus.A;
                            is_div_d  = op_div;
                            neg_res_d = op_signed && (bus.A[W-1] ^ bus.B[W-1]);
                            neg_rem_d = op_signed && bus.A[W-1];
                            div0_d    = op_div && (bus.B == '0);
                        end
                        OP_MTHI: hi_d = bus.A;
                        OP_MTLO: lo_d = bus.A;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        if (!rem_diff[W]) begin
                            acc_d = rem_diff[W-1:0];
                            mq_d  = {mq_q[W-2:0], 1'b1};
                        end else begin
                            acc_d = rem_shift[W-1:0];
                            mq_d  = {mq_q[W-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = mul_sum[W:1];
                        mq_d  = {mul_sum[0], mq_q[W-1:1]};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.abort) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*W-1:W];
                        lo_d = prod_fix[W-1:0];
                    end else if (div0_q) begin
                        hi_d = a_orig_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            opnd_q    <= '0;
            a_orig_q  <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            opnd_q    <= opnd_d;
            a_orig_q  <= a_orig_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a vector table of MULT*/DIV* operations plus
// hand-written sequences for MTHI/MTLO, abort, start-while-busy and async reset.
module tb_mul_div_unit;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one MULT*/DIV* and follow it to completion; optionally inject MTLO at cycle inj_k.
    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int inj_k);
        int lat;
        int busy_drops;
        lat = 0;
        busy_drops = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = op; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.start = 1'b0; bus.md_op = 3'b000;
        chk({nm, "_busy_after_accept"}, {63'd0, bus.busy}, 64'd1);
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            if (k == inj_k) begin
                bus.start = 1'b1; bus.md_op = 3'b110; bus.A = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            if (k == inj_k) begin
                bus.start = 1'b0; bus.md_op = 3'b000;
            end
            if (bus.done) lat = k;
            else if (!bus.busy) busy_drops++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd33);
        chk({nm, "_busy_held"}, 64'(busy_drops), 64'd0);
        chk({nm, "_busy_at_done"}, {63'd0, bus.busy}, 64'd0);
        chk({nm, "_hi"}, {32'd0, bus.hi}, {32'd0, eh});
        chk({nm, "_lo"}, {32'd0, bus.lo}, {32'd0, el});
        @(negedge clk);
        chk({nm, "_done_width"}, {63'd0, bus.done}, 64'd0);
        $display("%s op=%0d A=%h B=%h -> hi=%h lo=%h lat=%0d", nm, op, a, b, bus.hi, bus.lo, lat);
    endtask

    // Single-cycle request in IDLE (MTHI/MTLO/nop), optionally with abort.
    task automatic idle_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                           input logic ab, input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = op; bus.A = a; bus.abort = ab;
        @(negedge clk);
        bus.start = 1'b0; bus.md_op = 3'b000; bus.abort = 1'b0;
        chk({nm, "_busy"}, {63'd0, bus.busy}, 64'd0);
        chk({nm, "_done"}, {63'd0, bus.done}, 64'd0);
        chk({nm, "_hi"}, {32'd0, bus.hi}, {32'd0, eh});
        chk({nm, "_lo"}, {32'd0, bus.lo}, {32'd0, el});
        $display("%s op=%0d A=%h abort=%0d -> hi=%h lo=%h", nm, op, a, ab, bus.hi, bus.lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        total = 0;
        bad   = 0;
        vecs[0]  = '{3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{3'b100, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[4]  = '{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[6]  = '{3'b010, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[7]  = '{3'b100, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[8]  = '{3'b011, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{3'b011, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
        vecs[10] = '{3'b001, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        vecs[11] = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};

        rst = 1'b1;
        bus.start = 1'b0; bus.md_op = 3'b000; bus.A = '0; bus.B = '0; bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("reset_done", {63'd0, bus.done}, 64'd0);
        chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, 0);
        end

        // MTHI/MTLO and ignored opcodes in IDLE
        idle_op("mthi", 3'b101, 32'h1234_5678, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF);
        idle_op("mtlo", 3'b110, 32'h0000_5555, 1'b0, 32'h1234_5678, 32'h0000_5555);
        idle_op("nop7", 3'b111, 32'hAAAA_AAAA, 1'b0, 32'h1234_5678, 32'h0000_5555);
        idle_op("mthi_abort", 3'b101, 32'hCAFE_0000, 1'b1, 32'h1234_5678, 32'h0000_5555);
        idle_op("mult_abort", 3'b001, 32'h0000_0003, 1'b1, 32'h1234_5678, 32'h0000_5555);

        // MTLO presented mid-operation must be dropped
        run_op("mtlo_busy", 3'b010, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 5);

        // abort at cycle 10 of DIVU
        idle_op("pre_hi", 3'b101, 32'hAAAA_0000, 1'b0, 32'hAAAA_0000, 32'h0000_000F);
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 3'b100; bus.A = 32'd100; bus.B = 32'd7;
        @(negedge clk);
        bus.start = 1'b0; bus.md_op = 3'b000;
        repeat (9) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort10_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort10_hilo", {bus.hi, bus.lo}, {32'hAAAA_0000, 32'h0000_000F});
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("abort10_no_done", 64'(dones), 64'd0);
        $display("abort10 DIVU -> hi=%h lo=%h dones=%0d", bus.hi, bus.lo, dones);

        // abort landing in the FIX cycle
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 3'b010; bus.A = 32'd3; bus.B = 32'd5;
        @(negedge clk);
        bus.start = 1'b0; bus.md_op = 3'b000;
        repeat (32) @(negedge clk);
        chk("abortfix_busy_in_fix", {63'd0, bus.busy}, 64'd1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abortfix_busy", {63'd0, bus.busy}, 64'd0);
        chk("abortfix_done", {63'd0, bus.done}, 64'd0);
        chk("abortfix_hilo", {bus.hi, bus.lo}, {32'hAAAA_0000, 32'h0000_000F});
        $display("abortfix MULTU -> hi=%h lo=%h", bus.hi, bus.lo);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 3'b001; bus.A = 32'd9; bus.B = 32'd9;
        @(negedge clk);
        bus.start = 1'b0; bus.md_op = 3'b000;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {63'd0, bus.busy}, 64'd0);
        chk("arst_done", {63'd0, bus.done}, 64'd0);
        chk("arst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("arst_no_done", 64'(dones), 64'd0);
        $display("arst mid-CALC -> hi=%h lo=%h dones=%0d", bus.hi, bus.lo, dones);
        run_op("post_rst", 3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
